dcr_trace_buffer: RTL and testbench
===================================

# dcr_trace_buffer

Instruction-trace capture buffer sitting directly downstream of the single-core pipeline top level. It consumes the per-cycle fetch/decode observation outputs (instruction word, PC+1, PC source, register-write and memory-write strobes) and stores them in a circular buffer. Capture is controlled by a PC-match trigger with a programmable post-trigger window. After the window closes, the host reads the frozen history out through a simple request/valid port.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 4
- POST_DEPTH, 8, entries captured after the trigger entry; range 1..DEPTH-1
- clk  in  1  system clock, same clock as the pipeline
- rst  in  1  asynchronous, active-high reset
- clken  in  1  pipeline clock enable; a capture occurs only on cycles with clken=1
- TraceInstructionIn  in  32  instruction word from the fetch stage
- TracePCIn  in  8  PC+1 of that instruction
- TracePCSrcIn  in  2  PC source select for the same cycle
- TraceRegWriteIn  in  1  register-write strobe
- TraceMemWriteIn  in  1  memory-write strobe
- ArmIn  in  1  arm request (single-cycle pulse)
- TrigPCIn  in  8  trigger PC+1 value; must be held stable while armed
- RdReqIn  in  1  host read request (pop oldest entry)
- RdDataOut  out  44  popped entry: {PCSrc[1:0], MemWrite, RegWrite, PC[7:0], Instruction[31:0]}
- RdValidOut  out  1  RdDataOut valid, one-cycle pulse
- EmptyOut  out  1  buffer holds no entries
- FullOut  out  1  buffer holds DEPTH entries
- CountOut  out  $clog2(DEPTH+1)  number of stored entries
- StateOut  out  2  current state encoding

## Operation
- States: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE:
  - No capture.
  - ArmIn=1 clears the pointers and count, then moves to ARMED.
- ARMED:
  - Every clken=1 cycle writes one entry at the write pointer.
  - If the buffer is full, the oldest entry is overwritten: the read pointer advances and the count stays at DEPTH.
- Trigger:
  - Fires in ARMED on a capture cycle when TracePCIn == TrigPCIn.
  - The triggering entry is itself captured.
  - The post counter loads POST_DEPTH and the state moves to POST.
- POST:
  - Each capture cycle writes one entry, overwriting when full, and decrements the post counter.
  - The capture that brings the counter to 0 moves the state to DONE.
- DONE:
  - Capture is frozen.
  - RdReqIn=1 with EmptyOut=0 pops the entry at the read pointer and decrements the count.
  - ArmIn=1 discards all contents and moves to ARMED.
  - When ArmIn and RdReqIn are both high on the same cycle, ArmIn wins: no RdValidOut pulse.
- Ignored inputs:
  - ArmIn in ARMED or POST.
  - RdReqIn outside DONE, or when EmptyOut=1 (RdValidOut stays 0).
- Pointer and count arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - The count never exceeds DEPTH and never underflows.
- FullOut = (CountOut == DEPTH); EmptyOut = (CountOut == 0).
- clken gates capture only. Arm and read handling run on every clk edge.

## Timing
- All state, pointers, count and outputs are registered on the rising edge of clk.
- Reset values:
  - State = IDLE, pointers = 0, count = 0.
  - RdDataOut = 0, RdValidOut = 0.
  - EmptyOut = 1, FullOut = 0, CountOut = 0, StateOut = 0.
- A capture on edge N is reflected in CountOut after edge N.
- The trigger is evaluated from same-cycle inputs. StateOut shows POST after that edge.
- Read latency:
  - RdReqIn sampled high on edge N produces RdDataOut and RdValidOut=1 after edge N (one-cycle latency).
  - RdValidOut is low on every other cycle.
  - Back-to-back requests give back-to-back data.
- ArmIn on edge N gives StateOut=ARMED and EmptyOut=1 after edge N. The first capture can occur on edge N+1.
- Reset asserted mid-capture or mid-readout immediately returns every output to its reset value. Stored RAM contents are not cleared and are unreachable afterwards.

## Structure
- Package dcr_trace_pkg holds:
  - the state enum (trace_state_t, 2 bits);
  - the packed entry struct trace_entry_t (44 bits, field order as RdDataOut);
  - the state encoding constants.
- Sub-module dcr_trace_ram: DEPTH x 44 register array with one synchronous write port and one registered read port, no reset on the storage.
- The top of this block holds the FSM, pointers, count and post counter.

## Test plan
- Reset, then ArmIn; drive 5 captures with no PC match; hold (no ArmIn/RdReqIn) -> CountOut=5, StateOut=ARMED, RdReqIn ignored with RdValidOut=0.
- DEPTH=16, POST_DEPTH=8: arm, feed PC 0x01..0x28 with TrigPCIn=0x14 -> DONE after PC 0x1C, CountOut=16, first read returns PC 0x0D, last read returns 0x1C, then EmptyOut=1.
- Same as above but clken toggles 1/0 every cycle -> identical entries; only clken=1 cycles are captured.
- Trigger on the 2nd capture (PC 0x02), POST_DEPTH=8 -> DONE with CountOut=10, FullOut=0, reads return PC 0x01..0x0A in order.
- In DONE with 3 entries, assert ArmIn and RdReqIn together -> no RdValidOut, CountOut=0, StateOut=ARMED.
- Assert rst during POST with CountOut=12 -> all outputs at reset values asynchronously; StateOut=IDLE, EmptyOut=1.

Source files
------------

// File: rtl/dcr_trace_pkg.sv
// Shared types for the instruction-trace capture buffer: FSM state,
// stored entry layout and the state encoding seen on StateOut.
package dcr_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam logic [1:0] STATE_ENC_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ENC_ARMED = 2'd1;
    localparam logic [1:0] STATE_ENC_POST  = 2'd2;
    localparam logic [1:0] STATE_ENC_DONE  = 2'd3;

    localparam int ENTRY_W = 44;

    // Field order matches RdDataOut, MSB first.
    typedef struct packed {
        logic [1:0]  pc_src;
        logic        mem_write;
        logic        reg_write;
        logic [7:0]  pc;
        logic [31:0] instruction;
    } trace_entry_t;

    function automatic trace_entry_t pack_entry(
        input logic [1:0]  pc_src,
        input logic        mem_write,
        input logic        reg_write,
        input logic [7:0]  pc,
        input logic [31:0] instruction
    );
        trace_entry_t e;
        e.pc_src      = pc_src;
        e.mem_write   = mem_write;
        e.reg_write   = reg_write;
        e.pc          = pc;
        e.instruction = instruction;
        return e;
    endfunction

endpackage

// File: rtl/dcr_trace_buffer_if.sv
// Trace observation inputs, arm/trigger control and host readout port of
// the trace buffer; the buffer is the slave, the pipeline/host the master.
interface dcr_trace_buffer_if #(parameter int DEPTH = 16);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      TraceInstructionIn;
    logic [7:0]       TracePCIn;
    logic [1:0]       TracePCSrcIn;
    logic             TraceRegWriteIn;
    logic             TraceMemWriteIn;
    logic             ArmIn;
    logic [7:0]       TrigPCIn;
    logic             RdReqIn;
    logic [43:0]      RdDataOut;
    logic             RdValidOut;
    logic             EmptyOut;
    logic             FullOut;
    logic [CNT_W-1:0] CountOut;
    logic [1:0]       StateOut;

    modport master (
        output TraceInstructionIn, TracePCIn, TracePCSrcIn, TraceRegWriteIn,
        output TraceMemWriteIn, ArmIn, TrigPCIn, RdReqIn,
        input  RdDataOut, RdValidOut, EmptyOut, FullOut, CountOut, StateOut
    );

    modport slave (
        input  TraceInstructionIn, TracePCIn, TracePCSrcIn, TraceRegWriteIn,
        input  TraceMemWriteIn, ArmIn, TrigPCIn, RdReqIn,
        output RdDataOut, RdValidOut, EmptyOut, FullOut, CountOut, StateOut
    );

endinterface

// File: rtl/dcr_trace_ram.sv
// DEPTH x 44 trace storage: one synchronous write port and one registered
// read port. Only the read register is reset; the array itself is not.
module dcr_trace_ram
    import dcr_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  trace_entry_t     wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output trace_entry_t     rdata
);

    trace_entry_t mem_r [DEPTH];
    trace_entry_t rdata_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds the last popped entry between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dcr_trace_buffer.sv
// Instruction-trace capture buffer: circular history of pipeline observations,
// PC-match trigger with a post-trigger window, then frozen host readout.
module dcr_trace_buffer
    import dcr_trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken,
    dcr_trace_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] POST_LOAD = PTR_W'(POST_DEPTH);

    trace_state_t     state_r;
    trace_state_t     state_nxt_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [PTR_W-1:0] post_cnt_r;
    logic [PTR_W-1:0] post_cnt_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             rd_valid_r;
    logic             capture_s;
    logic             pop_s;
    logic             trig_hit_s;
    trace_entry_t     entry_s;
    trace_entry_t     rd_entry_s;

    assign entry_s = pack_entry(bus.TracePCSrcIn, bus.TraceMemWriteIn,
                                bus.TraceRegWriteIn, bus.TracePCIn,
                                bus.TraceInstructionIn);

    // Next-state, pointer, count and post-window decode.
    always_comb begin
        state_nxt_s    = state_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        count_nxt_s    = count_r;
        post_cnt_nxt_s = post_cnt_r;
        capture_s      = 1'b0;
        pop_s          = 1'b0;
        trig_hit_s     = (bus.TracePCIn == bus.TrigPCIn);

        case (state_r)
            ST_IDLE: begin
                if (bus.ArmIn) begin
                    wr_ptr_nxt_s = PTR_ZERO;
                    rd_ptr_nxt_s = PTR_ZERO;
                    count_nxt_s  = CNT_ZERO;
                    state_nxt_s  = ST_ARMED;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (clken) begin
                    capture_s = 1'b1;
                    if (trig_hit_s) begin
                        post_cnt_nxt_s = POST_LOAD;
                        state_nxt_s    = ST_POST;
                    end else begin
                        state_nxt_s    = ST_ARMED;
                    end
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_POST: begin
                if (clken) begin
                    capture_s      = 1'b1;
                    post_cnt_nxt_s = post_cnt_r - PTR_ONE;
                    if (post_cnt_r == PTR_ONE) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_DONE: begin
                // Arm takes priority over a simultaneous read request.
                if (bus.ArmIn) begin
                    wr_ptr_nxt_s = PTR_ZERO;
                    rd_ptr_nxt_s = PTR_ZERO;
                    count_nxt_s  = CNT_ZERO;
                    state_nxt_s  = ST_ARMED;
                end else if (bus.RdReqIn && !empty_r) begin
                    pop_s        = 1'b1;
                    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                    count_nxt_s  = count_r - CNT_ONE;
                end else begin
                    pop_s        = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A capture into a full buffer drops the oldest entry.
        if (capture_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            if (count_r == CNT_FULL) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                count_nxt_s  = count_r + CNT_ONE;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_nxt_s;
        end
    end

    // State, pointers, count and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            post_cnt_r <= PTR_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            post_cnt_r <= post_cnt_nxt_s;
            full_r     <= (count_nxt_s == CNT_FULL);
            empty_r    <= (count_nxt_s == CNT_ZERO);
            rd_valid_r <= pop_s;
        end
    end

    dcr_trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (capture_s),
        .waddr (wr_ptr_r),
        .wdata (entry_s),
        .re    (pop_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    assign bus.RdDataOut  = rd_entry_s;
    assign bus.RdValidOut = rd_valid_r;
    assign bus.EmptyOut   = empty_r;
    assign bus.FullOut    = full_r;
    assign bus.CountOut   = count_r;
    assign bus.StateOut   = state_r;

endmodule

// File: tb/tb_dcr_trace_buffer.sv
// Directed + randomized bench for dcr_trace_buffer, checked against a
// queue-based history model of the capture/trigger/readout rules.
module tb_dcr_trace_buffer;
    import dcr_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int POST  = 8;

    logic clk = 1'b0;
    logic rst;
    logic clken;

    always #5 clk = ~clk;

    dcr_trace_buffer_if #(.DEPTH(DEPTH)) bus();

    dcr_trace_buffer #(.DEPTH(DEPTH), .POST_DEPTH(POST)) dut (
        .clk   (clk),
        .rst   (rst),
        .clken (clken),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the history is a plain queue, oldest entry at the front.
    int          m_state;
    int          m_post;
    logic [43:0] q[$];
    logic        m_valid;
    logic [43:0] m_data;
    logic [7:0]  trig;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/count"}, 64'(bus.CountOut), 64'(q.size()));
        chk({tag, "/state"}, 64'(bus.StateOut), 64'(m_state));
        chk({tag, "/empty"}, 64'(bus.EmptyOut), 64'(q.size() == 0));
        chk({tag, "/full"},  64'(bus.FullOut),  64'(q.size() == DEPTH));
        chk({tag, "/valid"}, 64'(bus.RdValidOut), 64'(m_valid));
        chk({tag, "/data"},  64'(bus.RdDataOut), 64'(m_data));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_post  = 0;
        q.delete();
        m_valid = 1'b0;
        m_data  = 44'd0;
    endtask

    task automatic model_edge(input logic ce, input logic [43:0] e, input logic arm, input logic rd);
        m_valid = 1'b0;
        if ((m_state == 0 || m_state == 3) && arm) begin
            q.delete();
            m_state = 1;
        end else if ((m_state == 1 || m_state == 2) && ce) begin
            q.push_back(e);
            if (q.size() > DEPTH) void'(q.pop_front());
            if (m_state == 1) begin
                if (e[39:32] == trig) begin
                    m_state = 2;
                    m_post  = POST;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end else if (m_state == 3 && rd && q.size() > 0) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end
    endtask

    task automatic step(input logic ce, input logic [7:0] pc, input logic arm, input logic rd);
        logic [43:0] e;
        bus.TraceInstructionIn = $urandom;
        bus.TracePCIn          = pc;
        bus.TracePCSrcIn       = 2'($urandom_range(0, 3));
        bus.TraceRegWriteIn    = 1'($urandom_range(0, 1));
        bus.TraceMemWriteIn    = 1'($urandom_range(0, 1));
        bus.TrigPCIn           = trig;
        bus.ArmIn              = arm;
        bus.RdReqIn            = rd;
        clken                  = ce;
        e = {bus.TracePCSrcIn, bus.TraceMemWriteIn, bus.TraceRegWriteIn,
             bus.TracePCIn, bus.TraceInstructionIn};
        @(posedge clk);
        #1;
        model_edge(ce, e, arm, rd);
        check_all("step");
        bus.ArmIn   = 1'b0;
        bus.RdReqIn = 1'b0;
        clken       = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        clken                  = 1'b0;
        bus.TraceInstructionIn = 32'd0;
        bus.TracePCIn          = 8'd0;
        bus.TracePCSrcIn       = 2'd0;
        bus.TraceRegWriteIn    = 1'b0;
        bus.TraceMemWriteIn    = 1'b0;
        bus.ArmIn              = 1'b0;
        bus.TrigPCIn           = 8'd0;
        bus.RdReqIn            = 1'b0;
        trig                   = 8'hFF;
        #12;
        apply_reset();

        // Five non-matching captures, then idle cycles and an ignored read.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t1_count", 64'(bus.CountOut), 64'd5);
        chk("t1_state", 64'(bus.StateOut), 64'(STATE_ENC_ARMED));
        chk("t1_novalid", 64'(bus.RdValidOut), 64'd0);

        // Trigger at 0x14 with wrap-around, then full readout.
        apply_reset();
        trig = 8'h14;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int pc = 1; pc <= 8'h28; pc++) step(1'b1, 8'(pc), 1'b0, 1'b0);
        chk("t2_state", 64'(bus.StateOut), 64'(STATE_ENC_DONE));
        chk("t2_count", 64'(bus.CountOut), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (i == 0)  chk("t2_first_pc", 64'(bus.RdDataOut[39:32]), 64'h0D);
            if (i == 15) chk("t2_last_pc",  64'(bus.RdDataOut[39:32]), 64'h1C);
        end
        chk("t2_empty", 64'(bus.EmptyOut), 64'd1);

        // Same run with clken toggling; off cycles present the trigger PC.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int pc = 1; pc <= 8'h28; pc++) begin
            step(1'b1, 8'(pc), 1'b0, 1'b0);
            step(1'b0, 8'h14, 1'b0, 1'b0);
        end
        chk("t3_state", 64'(bus.StateOut), 64'(STATE_ENC_DONE));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (i == 0)  chk("t3_first_pc", 64'(bus.RdDataOut[39:32]), 64'h0D);
            if (i == 15) chk("t3_last_pc",  64'(bus.RdDataOut[39:32]), 64'h1C);
        end

        // Early trigger on the second capture: partial buffer.
        trig = 8'h02;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int pc = 1; pc <= 12; pc++) step(1'b1, 8'(pc), 1'b0, 1'b0);
        chk("t4_count", 64'(bus.CountOut), 64'd10);
        chk("t4_full",  64'(bus.FullOut), 64'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk("t4_pc", 64'(bus.RdDataOut[39:32]), 64'(i + 1));
        end

        // Arm and read together with three entries left: arm wins.
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t5_novalid", 64'(bus.RdValidOut), 64'd0);
        chk("t5_count",   64'(bus.CountOut), 64'd0);
        chk("t5_state",   64'(bus.StateOut), 64'(STATE_ENC_ARMED));

        // Asynchronous reset in the middle of the post window.
        trig = 8'h05;
        for (int pc = 1; pc <= 12; pc++) step(1'b1, 8'(pc), 1'b0, 1'b0);
        chk("t6_count", 64'(bus.CountOut), 64'd12);
        chk("t6_state", 64'(bus.StateOut), 64'(STATE_ENC_POST));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_state", 64'(bus.StateOut), 64'(STATE_ENC_IDLE));
        chk("t6_rst_empty", 64'(bus.EmptyOut), 64'd1);
        chk("t6_rst_count", 64'(bus.CountOut), 64'd0);
        chk("t6_rst_data",  64'(bus.RdDataOut), 64'd0);
        apply_reset();

        // Randomized runs against the history model.
        for (int run = 0; run < 4; run++) begin
            apply_reset();
            trig = 8'($urandom_range(0, 7));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            for (int c = 0; c < 300 && m_state != 3; c++)
                step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                     1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0));
            for (int c = 0; c < 40; c++)
                step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                     1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
